shift_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter with a valid/ready handshake on both sides.
//  It is the multi-cycle successor of the single-cycle 32-bit shifter: width and

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_pipe_stage.sv | 103 ++++++++++
 rtl/shift_pipe.sv | 79 +++++++
 tb/tb_shift_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared definitions for the pipelined barrel shifter: shift
//                mode encoding and the per-stage level-range helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    // Shift mode encoding carried with every beat through the pipe.
    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_ROTR = 2'b11
    } sh_mode_t;

    // First log2 level owned by stage k when 'levels' levels are spread over
    // 'stages' register stages. Stage k owns [stage_lo(k), stage_lo(k+1)).
    function automatic int stage_lo(input int k, input int levels, input int stages);
        return (k * levels) / stages;
    endfunction

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift_pipe_stage.sv
// ============================================================================
//  Module      : shift_pipe_stage
//  Description : One elastic stage of the barrel shifter. Applies log2 levels
//                [LO,HI) combinationally and registers valid/data/sa/mode.
//                Build option SHIFT_PIPE_ROTATE_EN adds the rotate datapath;
//                without it mode 11 shifts exactly like SRL.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SAW   = 5,
    parameter int LO    = 0,
    parameter int HI    = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_d,
    input  logic [SAW-1:0]   in_sa,
    input  sh_mode_t         in_mode,
    input  logic             next_adv,
    output logic             adv,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_d,
    output logic [SAW-1:0]   out_sa,
    output sh_mode_t         out_mode
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SAW-1:0]   sa_q,    sa_d;
    sh_mode_t         mode_q,  mode_d;
    logic [WIDTH-1:0] shifted;

    // One shift level by a fixed amount. SRA keeps the MSB at every level, so
    // the original sign bit is still in place for later stages.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] v,
                                                     input sh_mode_t         m,
                                                     input int               amt);
        logic [WIDTH-1:0] r;
        case (m)
            SH_SLL:  r = v << amt;
            SH_SRA:  r = $signed(v) >>> amt;
`ifdef SHIFT_PIPE_ROTATE_EN
            SH_ROTR: r = (v >> amt) | (v << (WIDTH - amt));
`endif
            default: r = v >> amt;
        endcase
        return r;
    endfunction

    // Levels owned by this stage, MSB level first: level i shifts by WIDTH>>(i+1).
    always_comb begin
        shifted = in_d;
        for (int i = LO; i < HI; i++) begin
            if (in_sa[SAW-1-i]) begin
                shifted = shift_level(shifted, in_mode, WIDTH >> (i + 1));
            end
        end
    end

    // Advance when empty or when the downstream side takes our beat; else hold.
    always_comb begin
        adv     = !valid_q || next_adv;
        valid_d = valid_q;
        data_d  = data_q;
        sa_d    = sa_q;
        mode_d  = mode_q;
        if (adv) begin
            valid_d = in_valid;
            data_d  = shifted;
            sa_d    = in_sa;
            mode_d  = in_mode;
        end
    end

    // Stage register; reset empties the stage and clears its payload.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sa_q    <= '0;
            mode_q  <= SH_SLL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sa_q    <= sa_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = valid_q;
    assign out_d     = data_q;
    assign out_sa    = sa_q;
    assign out_mode  = mode_q;

endmodule : shift_pipe_stage

`default_nettype wire

// File: rtl/shift_pipe.sv
// ============================================================================
//  Module      : shift_pipe
//  Description : Parametrised pipelined barrel shifter (SLL/SRL/SRA/ROTR) with
//                valid/ready on both sides and a zero flag. Latency equals
//                PIPE_STAGES, throughput one beat per cycle.
//                Build option SHIFT_PIPE_ROTATE_EN enables ROTR for mode 11;
//                without it mode 11 behaves as SRL.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int PIPE_STAGES = 2,
    localparam int SAW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d,
    input  logic [SAW-1:0]   in_sa,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sh,
    output logic             out_zero
);

    // Element k is the input of stage k; element PIPE_STAGES is the output.
    logic             stg_valid [0:PIPE_STAGES];
    logic [WIDTH-1:0] stg_d     [0:PIPE_STAGES];
    logic [SAW-1:0]   stg_sa    [0:PIPE_STAGES];
    sh_mode_t         stg_mode  [0:PIPE_STAGES];
    // stg_adv[k] is the advance of stage k; the last entry is the sink's ready.
    logic             stg_adv   [0:PIPE_STAGES];

    assign stg_valid[0]         = in_valid;
    assign stg_d[0]             = in_d;
    assign stg_sa[0]            = in_sa;
    assign stg_mode[0]          = sh_mode_t'(in_mode);
    assign stg_adv[PIPE_STAGES] = out_ready;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        shift_pipe_stage #(
            .WIDTH (WIDTH),
            .SAW   (SAW),
            .LO    (stage_lo(k,     SAW, PIPE_STAGES)),
            .HI    (stage_lo(k + 1, SAW, PIPE_STAGES))
        ) u_stage (
            .clk       (clk),
            .clrn      (clrn),
            .in_valid  (stg_valid[k]),
            .in_d      (stg_d[k]),
            .in_sa     (stg_sa[k]),
            .in_mode   (stg_mode[k]),
            .next_adv  (stg_adv[k+1]),
            .adv       (stg_adv[k]),
            .out_valid (stg_valid[k+1]),
            .out_d     (stg_d[k+1]),
            .out_sa    (stg_sa[k+1]),
            .out_mode  (stg_mode[k+1])
        );
    end

    assign in_ready  = stg_adv[0];
    assign out_valid = stg_valid[PIPE_STAGES];
    assign out_sh    = stg_d[PIPE_STAGES];
    assign out_zero  = (stg_d[PIPE_STAGES] == '0);

    // Shift amount and mode are fully consumed by the time they leave the last stage.
    logic unused_tail;
    assign unused_tail = ^{stg_sa[PIPE_STAGES], stg_mode[PIPE_STAGES]};

endmodule : shift_pipe

`default_nettype wire

// File: tb/tb_shift_pipe.sv
// ============================================================================
//  Module      : tb_shift_pipe
//  Description : Directed and random self-checking bench for shift_pipe
//                (WIDTH=32, PIPE_STAGES=2). Expected ROTR results follow the
//                SHIFT_PIPE_ROTATE_EN build option.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_pipe;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_d = '0;
    logic [4:0]  in_sa = '0;
    logic [1:0]  in_mode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sh;
    logic        out_zero;

    int n_checks = 0;
    int n_pass   = 0;

    shift_pipe #(.WIDTH(32), .PIPE_STAGES(2)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d      (in_d),
        .in_sa     (in_sa),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh    (out_sh),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Straightforward reference shifter.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sa,
                                              input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'b00:   r = d << sa;
            2'b01:   r = d >> sa;
            2'b10:   r = $signed(d) >>> sa;
            default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
                r = (d >> sa) | (d << (32 - int'(sa)));
`else
                r = d >> sa;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic test_reset();
        #2 clrn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_sh !== 32'h0) $display("FAIL reset_sh: out_sh=%h expected 00000000", out_sh);
        else n_pass++;
        n_checks++;
        if (out_zero !== 1'b1) $display("FAIL reset_zero: out_zero=%b expected 1", out_zero);
        else n_pass++;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready);
        else n_pass++;
    endtask

    // One isolated beat with out_ready=1: result must appear exactly 2 edges later.
    task automatic test_single(input string name, input logic [31:0] d, input logic [4:0] sa,
                               input logic [1:0] m, input logic [31:0] exp);
        @(negedge clk);
        out_ready = 1'b1;
        in_d = d; in_sa = sa; in_mode = m; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL %s_early: out_valid=%b expected 0", name, out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL %s_latency: out_valid=%b expected 1", name, out_valid);
        else n_pass++;
        n_checks++;
        if (out_sh !== exp) $display("FAIL %s_data: out_sh=%h expected %h", name, out_sh, exp);
        else n_pass++;
        n_checks++;
        if (out_zero !== (exp == 32'h0)) $display("FAIL %s_zero: out_zero=%b expected %b", name, out_zero, exp == 32'h0);
        else n_pass++;
    endtask

    task automatic test_modes();
        test_single("sll31",  32'h0000_0001, 5'd31, SH_SLL, 32'h8000_0000);
        test_single("sra4",   32'h8000_0000, 5'd4,  SH_SRA, 32'hF800_0000);
        test_single("srl4",   32'h8000_0000, 5'd4,  SH_SRL, 32'h0800_0000);
        test_single("sa0_sll",  32'hA5C3_0F81, 5'd0, SH_SLL,  32'hA5C3_0F81);
        test_single("sa0_srl",  32'hA5C3_0F81, 5'd0, SH_SRL,  32'hA5C3_0F81);
        test_single("sa0_sra",  32'hA5C3_0F81, 5'd0, SH_SRA,  32'hA5C3_0F81);
        test_single("sa0_rotr", 32'hA5C3_0F81, 5'd0, SH_ROTR, 32'hA5C3_0F81);
`ifdef SHIFT_PIPE_ROTATE_EN
        test_single("rotr8",  32'h1234_5678, 5'd8,  SH_ROTR, 32'h7812_3456);
`else
        test_single("rotr8",  32'h1234_5678, 5'd8,  SH_ROTR, 32'h0012_3456);
`endif
        test_single("sll_zero", 32'h0000_0000, 5'd3, SH_SLL, 32'h0000_0000);
    endtask

    task automatic test_backpressure();
        logic [31:0] bd [4];
        logic [4:0]  bs [4];
        logic [1:0]  bm [4];
        logic [31:0] be [4];
        int acc = 0;
        int got = 0;
        bd[0] = 32'h0000_00F0; bs[0] = 5'd4; bm[0] = SH_SRL; be[0] = 32'h0000_000F;
        bd[1] = 32'h0000_000F; bs[1] = 5'd4; bm[1] = SH_SLL; be[1] = 32'h0000_00F0;
        bd[2] = 32'h8000_0000; bs[2] = 5'd8; bm[2] = SH_SRA; be[2] = 32'hFF80_0000;
        bd[3] = 32'hDEAD_BEEF; bs[3] = 5'd0; bm[3] = SH_SLL; be[3] = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (acc < 4) begin
                in_d = bd[acc]; in_sa = bs[acc]; in_mode = bm[acc]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) acc++;
        end
        n_checks++;
        if (acc !== 2) $display("FAIL bp_accepted: accepted=%0d expected 2", acc);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready: in_ready=%b expected 0", in_ready);
        else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got < 4; c++) begin
            if (c != 0) begin
                @(negedge clk);
                if (acc < 4) begin
                    in_d = bd[acc]; in_sa = bs[acc]; in_mode = bm[acc]; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_sh !== be[got]) $display("FAIL bp_beat%0d: out_sh=%h expected %h", got, out_sh, be[got]);
                else n_pass++;
                got++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 4) $display("FAIL bp_delivered: delivered=%0d expected 4", got);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] e;
        logic [31:0] prev_sh = '0;
        logic        prev_stall = 1'b0;
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 3000 && got < 100; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_sh !== prev_sh)
                    $display("FAIL rand_stall_hold: out_valid=%b out_sh=%h expected 1 %h", out_valid, out_sh, prev_sh);
                else n_pass++;
            end
            in_valid  = (sent < 100) && ($urandom_range(3) != 0);
            in_d      = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
            in_sa     = 5'($urandom_range(31));
            in_mode   = 2'($urandom_range(3));
            out_ready = ($urandom_range(2) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_d, in_sa, in_mode));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra: out_sh=%h expected no beat", out_sh);
                end else begin
                    e = exp_q.pop_front();
                    if (out_sh !== e) $display("FAIL rand_data%0d: out_sh=%h expected %h", got, out_sh, e);
                    else n_pass++;
                    n_checks++;
                    if (out_zero !== (e == 32'h0)) $display("FAIL rand_zero%0d: out_zero=%b expected %b", got, out_zero, e == 32'h0);
                    else n_pass++;
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sh    = out_sh;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got !== 100 || exp_q.size() != 0)
            $display("FAIL rand_count: delivered=%0d pending=%0d expected 100 0", got, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        in_d = 32'h0000_0F00; in_sa = 5'd4; in_mode = SH_SLL; in_valid = 1'b1;
        @(negedge clk);
        in_d = 32'hFFFF_0000; in_sa = 5'd2; in_mode = SH_SRL;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL mid_inflight: out_valid=%b expected 1", out_valid);
        else n_pass++;
        #2 clrn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_async_valid: out_valid=%b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_sh !== 32'h0) $display("FAIL mid_async_sh: out_sh=%h expected 00000000", out_sh);
        else n_pass++;
        @(negedge clk);
        clrn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL mid_stale: stale beat seen=%b expected 0", seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shift_pipe

`default_nettype wire
